exe_muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide engine in the EXE stage. It consumes the operands and destination register that the ID/EXE pipeline register presents, and it stalls that register and the front end while it computes. It delivers a 64-bit HI/LO result together with the destination tag and a one-cycle completion pulse to the EXE/MEM path.

---
 rtl/exe_muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: iterative 32-bit multiply/divide engine for the EXE stage.
// Shift-add multiply (LSB first) or restoring divide (MSB first), one bit per
// cycle. Sign correction happens in a final SIGN cycle, which also registers
// the HI/LO results. While it works, the engine stalls ID/EXE and the front end.
module exe_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [4:0]  dest_in,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [4:0]  dest_out,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;       // op[1]: divide, op[0]: signed
  logic [4:0]  dest_q;
  logic [31:0] raw_a;      // unmodified dividend, returned on divide-by-zero
  logic        neg_q;
  logic        neg_r;
  logic [4:0]  count;
  logic [63:0] acc;        // multiply: running product
  logic [63:0] mcand;      // multiply: multiplicand, shifted left each step
  logic [31:0] mplier;     // multiply: multiplier shifted right; divide: divisor
  logic [31:0] rem;        // divide: partial remainder
  logic [31:0] quo;        // divide: dividend shifted out, quotient shifted in

  // Magnitude of a possibly signed operand; |0x80000000| stays 0x80000000.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  logic        is_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] trial;      // remainder shifted left with next dividend bit
  logic [31:0] diff;
  logic        fits;
  logic [63:0] acc_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Start-time operand conditioning plus one iteration step and sign fix-up.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    is_signed = op[0];
    mag_a     = mag(val1, is_signed);
    mag_b     = mag(val2, is_signed);
    trial     = {rem, quo[31]};
    fits      = trial >= {1'b0, mplier};
    diff      = trial[31:0] - mplier;  // exact whenever fits: result < divisor
    acc_next  = mplier[0] ? (acc + mcand) : acc;
    prod_fix  = neg_q ? (~acc + 64'd1) : acc;
    quo_fix   = neg_q ? (~quo + 32'd1) : quo;
    rem_fix   = neg_r ? (~rem + 32'd1) : rem;
  end

  // Stall covers the accepting IDLE cycle, every CALC cycle and SIGN.
  always_comb begin
    stall = (state == CALC) || (state == SIGN) ||
            ((state == IDLE) && start && !flush);
  end

  // Datapath: load operands on start, then iterate one bit per CALC cycle.
  // NOTE: these scratch registers carry no reset; they are always loaded on
  // start before being read, so resetting them would only add logic.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_q   <= op;
      dest_q <= dest_in;
      raw_a  <= val1;
      neg_q  <= is_signed & (val1[31] ^ val2[31]);
      neg_r  <= is_signed & val1[31];
      count  <= 5'd0;
      acc    <= 64'd0;
      mcand  <= {32'd0, mag_a};
      mplier <= mag_b;
      rem    <= 32'd0;
      quo    <= mag_a;
    end else if (state == CALC) begin
      count <= count + 5'd1;
      if (op_q[1]) begin
        rem <= fits ? diff : trial[31:0];
        quo <= {quo[30:0], fits};
      end else begin
        acc    <= acc_next;
        mcand  <= {mcand[62:0], 1'b0};
        mplier <= {1'b0, mplier[31:1]};
      end
    end
  end

  // Control FSM with registered done pulse and HI/LO result registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      result_lo   <= 32'd0;
      result_hi   <= 32'd0;
      dest_out    <= 5'd0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) state <= CALC;
          CALC: if (count == 5'd31) state <= SIGN;
          SIGN: begin
            dest_out <= dest_q;
            if (!op_q[1]) begin
              result_lo <= prod_fix[31:0];
              result_hi <= prod_fix[63:32];
            end else if (mplier == 32'd0) begin
              result_lo   <= 32'hFFFF_FFFF;
              result_hi   <= raw_a;
              div_by_zero <= 1'b1;
            end else begin
              result_lo   <= quo_fix;
              result_hi   <= rem_fix;
              div_by_zero <= 1'b0;
            end
            done  <= 1'b1;
            state <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Testbench for exe_muldiv_unit: scoreboard of expected HI/LO results pushed
// at issue and popped at the done pulse, plus flush/reset scenarios.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] val1 = 32'd0;
  logic [31:0] val2 = 32'd0;
  logic [4:0]  dest_in = 5'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [4:0]  dest_out;
  logic        div_by_zero;

  exe_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .val1(val1), .val2(val2),
    .dest_in(dest_in), .flush(flush), .stall(stall), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .dest_out(dest_out),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  dest;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  exp_t last = '0;   // architectural HI/LO state expected right now
  int total = 0;
  int bad   = 0;

  // Reference behaviour from native arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] d,
                                 input logic prev_dbz);
    exp_t m;
    logic [63:0] p;
    longint sa, sb_, q, r;
    m.dest = d;
    m.dbz  = prev_dbz;
    case (o)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; m.lo = p[31:0]; m.hi = p[63:32]; end
      2'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m.lo = p[31:0]; m.hi = p[63:32];
      end
      default: begin
        if (b == 32'd0) begin
          m.lo = 32'hFFFF_FFFF; m.hi = a; m.dbz = 1'b1;
        end else if (o == 2'd2) begin
          m.lo = a / b; m.hi = a % b; m.dbz = 1'b0;
        end else begin
          sa = longint'($signed(a)); sb_ = longint'($signed(b));
          q = sa / sb_; r = sa % sb_;
          m.lo = q[31:0]; m.hi = r[31:0]; m.dbz = 1'b0;
        end
      end
    endcase
    return m;
  endfunction

  // Issue one op at the current cycle t and check latency, stall length,
  // results and the single-cycle done pulse. Returns in cycle t+35.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input string nm);
    exp_t e, got;
    int lat, stalls;
    e = model(o, a, b, d, last.dbz);
    sb.push_back(e);
    last = e;
    op = o; val1 = a; val2 = b; dest_in = d; start = 1'b1;
    lat = -1; stalls = 0;
    for (int c = 0; c <= 40; c++) begin
      #1;
      if (stall) stalls++;
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b0;
    total++;
    if (lat !== 34) begin bad++; $display("FAIL %s latency: got %0d want 34", nm, lat); end
    total++;
    if (stalls !== 34) begin bad++; $display("FAIL %s stall_cycles: got %0d want 34", nm, stalls); end
    got = sb.pop_front();
    if (lat >= 0) begin
      total++;
      if (result_lo !== got.lo) begin bad++; $display("FAIL %s result_lo: got %h want %h", nm, result_lo, got.lo); end
      total++;
      if (result_hi !== got.hi) begin bad++; $display("FAIL %s result_hi: got %h want %h", nm, result_hi, got.hi); end
      total++;
      if (dest_out !== got.dest) begin bad++; $display("FAIL %s dest_out: got %0d want %0d", nm, dest_out, got.dest); end
      total++;
      if (div_by_zero !== got.dbz) begin bad++; $display("FAIL %s div_by_zero: got %b want %b", nm, div_by_zero, got.dbz); end
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL %s done_width: done still %b after one cycle", nm, done); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({stall, done, result_lo, result_hi, dest_out, div_by_zero} !== 71'd0) begin
      bad++;
      $display("FAIL reset_outputs: got stall=%b done=%b lo=%h hi=%h dest=%0d dbz=%b want all 0",
               stall, done, result_lo, result_hi, dest_out, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_mulu;
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, "mulu_max");
    total++;
    if ({result_hi, result_lo} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL mulu_max_const: got %h%h want fffffffe00000001", result_hi, result_lo);
    end
  endtask

  task automatic test_mul;
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 5'd6, "mul_neg3x7");
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, "mul_minxmin");
    total++;
    if ({result_hi, result_lo} !== 64'h4000_0000_0000_0000) begin
      bad++; $display("FAIL mul_minxmin_const: got %h%h want 4000000000000000", result_hi, result_lo);
    end
  endtask

  task automatic test_div;
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 5'd8, "div_neg7_2");
    total++;
    if ({result_lo, result_hi} !== 64'hFFFF_FFFD_FFFF_FFFF) begin
      bad++; $display("FAIL div_neg7_2_const: got lo=%h hi=%h want fffffffd ffffffff", result_lo, result_hi);
    end
    run_op(2'd2, 32'd100, 32'd7, 5'd9, "divu_100_7");
  endtask

  task automatic test_div_zero;
    run_op(2'd2, 32'd100, 32'd0, 5'd10, "divu_by_zero");
    total++;
    if ({div_by_zero, result_lo, result_hi} !== {1'b1, 32'hFFFF_FFFF, 32'd100}) begin
      bad++; $display("FAIL divu_by_zero_const: got dbz=%b lo=%h hi=%h want 1 ffffffff 00000064",
                      div_by_zero, result_lo, result_hi);
    end
    run_op(2'd1, 32'd3, 32'd4, 5'd11, "mul_keeps_dbz");
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "div_overflow");
  endtask

  task automatic test_flush;
    int saw_done;
    saw_done = 0;
    op = 2'd0; val1 = 32'd3; val2 = 32'd4; dest_in = 5'd13; start = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c == 10) flush = 1'b1;
      #1;
      if (done) saw_done++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall); end
    total++;
    if (done !== 1'b0 || saw_done != 0) begin bad++; $display("FAIL flush_done: got done=%b seen=%0d want none", done, saw_done); end
    total++;
    if ({result_lo, result_hi, dest_out, div_by_zero} !== {last.lo, last.hi, last.dest, last.dbz}) begin
      bad++; $display("FAIL flush_hold: got lo=%h hi=%h dest=%0d dbz=%b want lo=%h hi=%h dest=%0d dbz=%b",
                      result_lo, result_hi, dest_out, div_by_zero, last.lo, last.hi, last.dest, last.dbz);
    end
    run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, "after_flush");
  endtask

  task automatic test_start_flush;
    int bad_cycles;
    bad_cycles = 0;
    op = 2'd2; val1 = 32'd50; val2 = 32'd0; dest_in = 5'd15;
    start = 1'b1; flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL start_flush_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done !== 1'b0 || stall !== 1'b0) bad_cycles++;
      @(posedge clk); #1;
    end
    total++;
    if (bad_cycles != 0) begin bad++; $display("FAIL start_flush_idle: got %0d busy cycles want 0", bad_cycles); end
    total++;
    if ({result_lo, result_hi, dest_out, div_by_zero} !== {last.lo, last.hi, last.dest, last.dbz}) begin
      bad++; $display("FAIL start_flush_hold: got lo=%h hi=%h dest=%0d dbz=%b want lo=%h hi=%h dest=%0d dbz=%b",
                      result_lo, result_hi, dest_out, div_by_zero, last.lo, last.hi, last.dest, last.dbz);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 3) ? 32'd0 : $urandom;
      if (i == 5) a = 32'h8000_0000;
      run_op(o, a, b, 5'($urandom_range(0, 31)), $sformatf("b2b_%0d", i));
    end
  endtask

  task automatic test_rst_mid;
    int saw_done;
    saw_done = 0;
    op = 2'd3; val1 = 32'hFFFF_FF00; val2 = 32'd9; dest_in = 5'd20; start = 1'b1;
    for (int c = 0; c < 21; c++) begin
      if (c == 20) begin rst = 1'b1; flush = 1'b1; end
      #1;
      if (done) saw_done++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b0; flush = 1'b0;
    last = '0;
    #1;
    total++;
    if ({stall, done, result_lo, result_hi, dest_out, div_by_zero} !== 71'd0 || saw_done != 0) begin
      bad++;
      $display("FAIL rst_mid: got stall=%b done=%b lo=%h hi=%h dest=%0d dbz=%b seen=%0d want all 0",
               stall, done, result_lo, result_hi, dest_out, div_by_zero, saw_done);
    end
    @(posedge clk); #1;
    run_op(2'd2, 32'd1000, 32'd33, 5'd21, "after_rst");
  endtask

  initial begin
    test_reset();
    test_mulu();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_start_flush();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
